// File: rtl/layer0_input_packer_pkg.sv
// Shared layer-0 constants and types, so the input packer and the generated
// neuron LUT instances agree on the input vector width.
package layer0_input_packer_pkg;

   localparam int unsigned L0_IN_WIDTH = 192;

   typedef enum logic {
      FILL,
      DISCARD
   } fill_state_e;

   function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/layer0_vec_buffer.sv
// Two-entry ping-pong vector store: beat-granular writes into the write-side
// entry, whole-vector reads from the read-side entry with a valid/ready handshake.
module layer0_vec_buffer
   import layer0_input_packer_pkg::*;
#(
   parameter int unsigned IN_WIDTH   = L0_IN_WIDTH,
   parameter int unsigned BEAT_WIDTH = 32,
   parameter int unsigned BEATS      = ceil_div(IN_WIDTH, BEAT_WIDTH),
   parameter int unsigned IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  beat_we,
   input  logic [IDX_W-1:0]      beat_idx,
   input  logic [BEAT_WIDTH-1:0] beat_data,
   input  logic                  commit,
   input  logic                  rd_ready,
   output logic                  rd_valid,
   output logic [IN_WIDTH-1:0]   rd_data,
   output logic [1:0]            count_next
);

   // Entries are padded to whole beats; bits above IN_WIDTH never reach the output.
   localparam int unsigned PAD_WIDTH = BEATS * BEAT_WIDTH;

   logic [PAD_WIDTH-1:0] mem_q [2];
   logic [1:0]           count_q, count_d;
   logic                 wr_ptr_q, rd_ptr_q;
   logic                 rd_fire;

   assign rd_valid   = (count_q != 2'd0);
   assign rd_fire    = rd_valid && rd_ready;
   assign rd_data    = mem_q[rd_ptr_q][IN_WIDTH-1:0];
   assign count_next = count_d;

   always_comb begin
      count_d = count_q;
      case ({commit, rd_fire})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // The packer only writes while count < 2, so the write entry is never the
   // one being presented with rd_valid high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         if (beat_we) begin
            mem_q[wr_ptr_q][int'(beat_idx) * BEAT_WIDTH +: BEAT_WIDTH] <= beat_data;
         end
         if (commit) begin
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (rd_fire) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/layer0_input_packer.sv
// Stream-to-vector front end for the layer-0 LUT array: packs fixed-width beats
// into a full input vector, with framing checks and ping-pong buffering.
module layer0_input_packer
   import layer0_input_packer_pkg::*;
#(
   parameter int unsigned IN_WIDTH   = L0_IN_WIDTH,
   parameter int unsigned BEAT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [BEAT_WIDTH-1:0] s_data,
   input  logic                  s_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [IN_WIDTH-1:0]   m_data,
   output logic                  err,
   output logic [7:0]            drop_cnt
);

   localparam int unsigned BEATS = ceil_div(IN_WIDTH, BEAT_WIDTH);
   localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

   fill_state_e      state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             s_ready_q;
   logic             err_q, err_d;
   logic [7:0]       drop_q, drop_d;
   logic             accept, at_last, beat_we, commit, drop;
   logic [1:0]       count_next;

   assign accept  = s_valid && s_ready_q;
   assign at_last = (idx_q == LAST_IDX);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      beat_we = 1'b0;
      commit  = 1'b0;
      drop    = 1'b0;
      unique case (state_q)
         FILL: begin
            if (accept) begin
               beat_we = 1'b1;
               if (at_last) begin
                  idx_d = '0;
                  if (s_last) begin
                     commit = 1'b1;
                  end else begin
                     drop    = 1'b1;
                     state_d = DISCARD;
                  end
               end else if (s_last) begin
                  drop  = 1'b1;
                  idx_d = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         DISCARD: begin
            if (accept && s_last) begin
               state_d = FILL;
            end
         end
      endcase
   end

   assign err_d  = err_q | drop;
   assign drop_d = (drop && (drop_q != 8'hff)) ? drop_q + 8'd1 : drop_q;

   // s_ready looks only at registered occupancy, so m_ready never reaches it combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= FILL;
         idx_q     <= '0;
         s_ready_q <= 1'b0;
         err_q     <= 1'b0;
         drop_q    <= 8'd0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         s_ready_q <= (count_next < 2'd2);
         err_q     <= err_d;
         drop_q    <= drop_d;
      end
   end

   assign s_ready  = s_ready_q;
   assign err      = err_q;
   assign drop_cnt = drop_q;

   layer0_vec_buffer #(
      .IN_WIDTH   (IN_WIDTH),
      .BEAT_WIDTH (BEAT_WIDTH),
      .BEATS      (BEATS),
      .IDX_W      (IDX_W)
   ) u_vec_buffer (
      .clk        (clk),
      .rst        (rst),
      .beat_we    (beat_we),
      .beat_idx   (idx_q),
      .beat_data  (s_data),
      .commit     (commit),
      .rd_ready   (m_ready),
      .rd_valid   (m_valid),
      .rd_data    (m_data),
      .count_next (count_next)
   );

endmodule

// File: tb/tb_layer0_input_packer.sv
// Bench for layer0_input_packer: directed scenarios plus a random stream,
// all checked against a frame-level reference model.
module tb_layer0_input_packer;

   localparam int unsigned IN_WIDTH   = 192;
   localparam int unsigned BEAT_WIDTH = 32;
   localparam int unsigned BEATS      = 6;

   typedef logic [IN_WIDTH-1:0] vec_t;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  s_valid = 1'b0;
   logic                  s_ready;
   logic [BEAT_WIDTH-1:0] s_data = '0;
   logic                  s_last = 1'b0;
   logic                  m_valid;
   logic                  m_ready = 1'b0;
   logic [IN_WIDTH-1:0]   m_data;
   logic                  err;
   logic [7:0]            drop_cnt;

   always #5 clk = ~clk;

   layer0_input_packer #(
      .IN_WIDTH   (IN_WIDTH),
      .BEAT_WIDTH (BEAT_WIDTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .s_last   (s_last),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .err      (err),
      .drop_cnt (drop_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input vec_t got, input vec_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: whole vectors in flight plus the beats of the current frame.
   vec_t                  exp_q[$];
   logic [BEAT_WIDTH-1:0] frame[$];
   bit                    overrun   = 1'b0;
   bit                    exp_err   = 1'b0;
   int                    exp_drop  = 0;
   bit                    accepted  = 1'b0;
   bit                    rand_ready = 1'b0;
   int                    mv_pulses = 0;
   int                    sready_low = 0;

   function automatic vec_t mkvec(input int unsigned base);
      vec_t v = '0;
      for (int k = 0; k < BEATS; k++) v[k*BEAT_WIDTH +: BEAT_WIDTH] = BEAT_WIDTH'(base + k);
      return v;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      frame.delete();
      overrun  = 1'b0;
      exp_err  = 1'b0;
      exp_drop = 0;
   endtask

   task automatic model_drop();
      exp_err = 1'b1;
      if (exp_drop < 255) exp_drop++;
   endtask

   task automatic model_beat(input logic [BEAT_WIDTH-1:0] d, input logic last);
      vec_t v;
      if (overrun) begin
         if (last) overrun = 1'b0;
         return;
      end
      frame.push_back(d);
      if (last) begin
         if (frame.size() == BEATS) begin
            v = '0;
            foreach (frame[k]) v[k*BEAT_WIDTH +: BEAT_WIDTH] = frame[k];
            exp_q.push_back(v);
         end else begin
            model_drop();
         end
         frame.delete();
      end else if (frame.size() == BEATS) begin
         model_drop();
         overrun = 1'b1;
         frame.delete();
      end
   endtask

   // One clock: sample handshakes mid-cycle, advance, update model, check outputs.
   task automatic step();
      bit                    acc, rd;
      logic [BEAT_WIDTH-1:0] d;
      logic                  l;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      acc = s_valid && s_ready;
      rd  = m_valid && m_ready;
      d   = s_data;
      l   = s_last;
      @(posedge clk);
      #1;
      accepted = acc;
      if (rst) return;
      if (m_valid) mv_pulses++;
      if (!s_ready) sready_low++;
      if (rd) void'(exp_q.pop_front());
      if (acc) model_beat(d, l);
      check_eq("m_valid", vec_t'(m_valid), vec_t'(exp_q.size() != 0));
      check_eq("s_ready", vec_t'(s_ready), vec_t'(exp_q.size() < 2));
      check_eq("err", vec_t'(err), vec_t'(exp_err));
      check_eq("drop_cnt", vec_t'(drop_cnt), vec_t'(exp_drop));
      if (exp_q.size() != 0) check_eq("m_data", m_data, exp_q[0]);
   endtask

   task automatic send_beat(input logic [BEAT_WIDTH-1:0] d, input logic last);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      for (int i = 0; i < 200; i++) begin
         step();
         if (accepted) return;
      end
      check_eq("accept_timeout", vec_t'(accepted), vec_t'(1));
   endtask

   task automatic send_frame(input int unsigned base, input int len, input int last_pos);
      for (int k = 0; k < len; k++) send_beat(BEAT_WIDTH'(base + k), k == last_pos);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic do_reset();
      s_valid = 1'b0;
      rst = 1'b1;
      model_reset();
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int len, r;
      #2;
      check_eq("reset_s_ready", vec_t'(s_ready), '0);
      check_eq("reset_m_valid", vec_t'(m_valid), '0);
      check_eq("reset_m_data", m_data, '0);
      check_eq("reset_drop_cnt", vec_t'(drop_cnt), '0);
      step();
      rst = 1'b0;
      step();

      // Basic vector, m_ready high.
      m_ready = 1'b1;
      send_frame(1, 6, 5);
      check_eq("t1_m_valid", vec_t'(m_valid), vec_t'(1));
      check_eq("t1_beat0", vec_t'(m_data[31:0]), vec_t'(1));
      check_eq("t1_beat5", vec_t'(m_data[191:160]), vec_t'(6));
      check_eq("t1_err", vec_t'(err), '0);
      step();
      step();

      // Two buffered vectors stall the third.
      m_ready = 1'b0;
      send_beat(32'd10, 1'b0);
      for (int k = 1; k < 6; k++) send_beat(BEAT_WIDTH'(10 + k), k == 5);
      for (int k = 0; k < 6; k++) send_beat(BEAT_WIDTH'(20 + k), k == 5);
      check_eq("t2_full_s_ready", vec_t'(s_ready), '0);
      s_valid = 1'b1;
      s_data  = 32'd30;
      s_last  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("t2_hold", m_data, mkvec(10));
      end
      m_ready = 1'b1;
      send_frame(30, 6, 5);
      for (int i = 0; i < 4; i++) step();

      // Early s_last drops the partial vector.
      do_reset();
      m_ready = 1'b1;
      send_frame(40, 3, 2);
      step();
      check_eq("t3_err", vec_t'(err), vec_t'(1));
      check_eq("t3_drop", vec_t'(drop_cnt), vec_t'(1));
      check_eq("t3_no_valid", vec_t'(m_valid), '0);
      send_frame(50, 6, 5);
      check_eq("t3_next_vec", m_data, mkvec(50));
      step();

      // Missing s_last: all eight beats discarded.
      do_reset();
      send_frame(60, 8, 7);
      step();
      check_eq("t4_drop", vec_t'(drop_cnt), vec_t'(1));
      check_eq("t4_no_valid", vec_t'(m_valid), '0);
      send_frame(70, 6, 5);
      check_eq("t4_next_vec", m_data, mkvec(70));
      step();

      // Continuous stream at full rate.
      mv_pulses  = 0;
      sready_low = 0;
      for (int v = 0; v < 4; v++) begin
         for (int k = 0; k < 6; k++) send_beat(BEAT_WIDTH'(100 + 10 * v + k), k == 5);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      step();
      step();
      check_eq("t5_pulses", vec_t'(mv_pulses), vec_t'(4));
      check_eq("t5_sready_low", vec_t'(sready_low), '0);

      // Async reset mid-vector with one vector buffered.
      m_ready = 1'b0;
      send_frame(200, 6, 5);
      for (int k = 0; k < 3; k++) send_beat(BEAT_WIDTH'(210 + k), 1'b0);
      s_data = 32'd213;
      #2;
      rst = 1'b1;
      #1;
      check_eq("t6_m_valid_async", vec_t'(m_valid), '0);
      check_eq("t6_m_data_async", m_data, '0);
      check_eq("t6_s_ready_async", vec_t'(s_ready), '0);
      s_valid = 1'b0;
      model_reset();
      step();
      step();
      rst = 1'b0;
      m_ready = 1'b1;
      step();
      send_frame(300, 6, 5);
      check_eq("t6_fresh_vec", m_data, mkvec(300));
      step();

      // Random framing, gaps and backpressure.
      do_reset();
      rand_ready = 1'b1;
      for (int f = 0; f < 150; f++) begin
         r = int'($urandom_range(0, 9));
         if (r < 7) len = 6;
         else if (r == 7) len = int'($urandom_range(1, 5));
         else len = 6 + int'($urandom_range(1, 3));
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               s_valid = 1'b0;
               step();
            end
            send_beat($urandom, k == len - 1);
         end
         s_valid = 1'b0;
         s_last  = 1'b0;
      end
      rand_ready = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();

      // drop_cnt saturation.
      do_reset();
      for (int f = 0; f < 260; f++) send_beat(BEAT_WIDTH'(f), 1'b1);
      s_valid = 1'b0;
      s_last  = 1'b0;
      step();
      check_eq("t8_drop_sat", vec_t'(drop_cnt), vec_t'(255));
      check_eq("t8_err", vec_t'(err), vec_t'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
